eh2_lsu_dc_way_mem: RTL and testbench

EH2_LSU_DC_WAY_MEM -- requirements
Module: eh2_lsu_dc_way_mem

---
 rtl/eh2_lsu_dc_way_mem.sv | 251 +++++++++++++++++++++++++
 tb/tb_eh2_lsu_dc_way_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_lsu_dc_way_mem.sv
// eh2_lsu_dc_way_mem: set-associative write-back data cache array serving one request at a time.
// Replacement is tree pseudo-LRU when DC_PLRU_EN is defined, otherwise a global round-robin counter.
module eh2_lsu_dc_way_mem #(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    req_we,
    input  logic [1:0]              req_op,
    input  logic [LINE_BYTES*8-1:0] req_wdata,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [LINE_BYTES*8-1:0] resp_data,
    output logic                    evict_valid,
    input  logic                    evict_ready,
    output logic [ADDR_W-1:0]       evict_addr,
    output logic [LINE_BYTES*8-1:0] evict_data,
    output logic                    fill_req,
    output logic [ADDR_W-1:0]       fill_addr,
    input  logic                    fill_valid,
    input  logic [LINE_BYTES*8-1:0] fill_data
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int LW     = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LW : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid-side outputs (evict_valid, fill_req) stay asserted with stable payload until that edge.

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];

    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [OFF_W-1:0]  req_off_q;
    logic              req_we_q;
    logic [1:0]        req_op_q;
    logic [LINE_W-1:0] req_wdata_q;
    logic [WAY_W-1:0]  victim_q;
    logic              victim_valid_q;
    logic              resp_hit_q;
    logic [LINE_W-1:0] resp_data_q;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] policy_way;
    logic [WAY_W-1:0] victim;
    logic             victim_valid;
    logic             victim_dirty;

`ifdef DC_PLRU_EN
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    logic [PLRU_W-1:0] plru_q [SETS];

    // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0] way;
        int node;
        way  = '0;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            way  = (way << 1) | WAY_W'(bits[node]);
            node = 2 * node + 1 + int'(bits[node]);
        end
        return way;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        logic b;
        int node;
        r    = bits;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            b       = way[LW-1-l];
            r[node] = ~b;
            node    = 2 * node + 1 + int'(b);
        end
        return r;
    endfunction
`else
    logic [WAY_W-1:0] rr_q;
`endif

    function automatic logic [LINE_W-1:0] merge_store(input logic [LINE_W-1:0] line,
                                                      input logic [1:0]        op,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic [LINE_W-1:0] wd);
        logic [LINE_W-1:0] mask;
        int sh;
        case (op)
            2'd0:    begin mask = LINE_W'(8'hFF);         sh = int'(off) * 8;        end
            2'd1:    begin mask = LINE_W'(32'hFFFF_FFFF); sh = int'(off >> 2) * 32; end
            default: begin mask = '1;                     sh = 0;                    end
        endcase
        mask = mask << sh;
        return (line & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic logic [LINE_W-1:0] load_data(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        op,
                                                    input logic [OFF_W-1:0]  off);
        logic [LINE_W-1:0] r;
        case (op)
            2'd0:    r = (line >> (int'(off) * 8)) & LINE_W'(8'hFF);
            2'd1:    r = (line >> (int'(off >> 2) * 32)) & LINE_W'(32'hFFFF_FFFF);
            default: r = line;
        endcase
        return r;
    endfunction

    // Tag compare across the set plus victim selection, all from the captured request.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx_q][w] && (tag_mem[req_idx_q][w] == req_tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx_q][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
`ifdef DC_PLRU_EN
        policy_way = (WAYS > 1) ? plru_victim(plru_q[req_idx_q]) : '0;
`else
        policy_way = (WAYS > 1) ? rr_q : '0;
`endif
        victim       = inv_found ? inv_way : policy_way;
        victim_valid = valid_q[req_idx_q][victim];
        victim_dirty = dirty_q[req_idx_q][victim];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP: begin
                if (hit)                               state_nxt = RESP;
                else if (victim_valid && victim_dirty) state_nxt = EVICT;
                else                                   state_nxt = FILL;
            end
            EVICT:   if (evict_ready) state_nxt = FILL;
            FILL:    if (fill_valid)  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Array writes sit in the non-reset branch so an abandoned EVICT/FILL never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifdef DC_PLRU_EN
                plru_q[s]  <= '0;
`endif
            end
`ifndef DC_PLRU_EN
            rr_q <= '0;
`endif
            resp_hit_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_tag_q   <= req_addr[ADDR_W-1:IDX_W+OFF_W];
                    req_idx_q   <= req_addr[IDX_W+OFF_W-1:OFF_W];
                    req_off_q   <= req_addr[OFF_W-1:0];
                    req_we_q    <= req_we;
                    req_op_q    <= req_op;
                    req_wdata_q <= req_wdata;
                end
                LOOKUP: begin
                    victim_q       <= victim;
                    victim_valid_q <= victim_valid;
                    if (hit) begin
                        if (req_we_q) begin
                            data_mem[req_idx_q][hit_way] <= merge_store(data_mem[req_idx_q][hit_way],
                                                                        req_op_q, req_off_q, req_wdata_q);
                            dirty_q[req_idx_q][hit_way]  <= 1'b1;
                            resp_data_q <= '0;
                        end else begin
                            resp_data_q <= load_data(data_mem[req_idx_q][hit_way], req_op_q, req_off_q);
                        end
                        resp_hit_q <= 1'b1;
`ifdef DC_PLRU_EN
                        plru_q[req_idx_q] <= plru_touch(plru_q[req_idx_q], hit_way);
`endif
                    end
                end
                EVICT: if (evict_ready) valid_q[req_idx_q][victim_q] <= 1'b0;
                FILL: if (fill_valid) begin
                    data_mem[req_idx_q][victim_q] <= req_we_q
                        ? merge_store(fill_data, req_op_q, req_off_q, req_wdata_q) : fill_data;
                    tag_mem[req_idx_q][victim_q] <= req_tag_q;
                    valid_q[req_idx_q][victim_q] <= 1'b1;
                    dirty_q[req_idx_q][victim_q] <= req_we_q;
                    resp_data_q <= req_we_q ? '0 : load_data(fill_data, req_op_q, req_off_q);
                    resp_hit_q  <= 1'b0;
`ifdef DC_PLRU_EN
                    plru_q[req_idx_q] <= plru_touch(plru_q[req_idx_q], victim_q);
`else
                    if (victim_valid_q && (WAYS > 1)) rr_q <= rr_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready   = !reset && (state == IDLE);
        resp_valid  = !reset && (state == RESP);
        evict_valid = !reset && (state == EVICT);
        fill_req    = !reset && (state == FILL);
        resp_hit    = resp_valid && resp_hit_q;
        resp_data   = resp_valid ? resp_data_q : '0;
        evict_addr  = evict_valid ? {tag_mem[req_idx_q][victim_q], req_idx_q, {OFF_W{1'b0}}} : '0;
        evict_data  = evict_valid ? data_mem[req_idx_q][victim_q] : '0;
        fill_addr   = fill_req ? {req_tag_q, req_idx_q, {OFF_W{1'b0}}} : '0;
    end

endmodule

// File: tb/tb_eh2_lsu_dc_way_mem.sv
// Bench for eh2_lsu_dc_way_mem: directed scenarios then random traffic against a line-level cache model.
module tb_eh2_lsu_dc_way_mem;
  localparam int WAYS = 2;
  localparam int SETS = 4;
  localparam int LINE_BYTES = 16;
  localparam int ADDR_W = 20;
  localparam int LW = LINE_BYTES * 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic req_we = 1'b0;
  logic [1:0] req_op = '0;
  logic [LW-1:0] req_wdata = '0;
  logic resp_valid, resp_hit;
  logic [LW-1:0] resp_data;
  logic evict_valid;
  logic evict_ready = 1'b0;
  logic [ADDR_W-1:0] evict_addr;
  logic [LW-1:0] evict_data;
  logic fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic fill_valid = 1'b0;
  logic [LW-1:0] fill_data = '0;

  eh2_lsu_dc_way_mem #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_op(req_op), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_addr(evict_addr), .evict_data(evict_data),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_valid(fill_valid), .fill_data(fill_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int n_req = 0;

  always @(posedge clk) if (!reset && req_valid && req_ready) acc_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: resident lines per set/way, backing memory keyed by line address
  logic          m_valid [SETS][WAYS];
  logic          m_dirty [SETS][WAYS];
  int            m_tag   [SETS][WAYS];
  logic [LW-1:0] m_data  [SETS][WAYS];
  int            m_mru   [SETS];
  int            m_rr;
  logic [LW-1:0] mem [int];

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      m_mru[s] = WAYS - 1;
    end
    m_rr = 0;
  endtask

  task automatic model_access(input int addr, input logic we, input logic [1:0] op, input logic [LW-1:0] wd,
                              output logic hit, output logic [LW-1:0] rdata, output logic ev,
                              output int ev_addr, output logic [LW-1:0] ev_data, output int line_addr);
    int set, tag, off, w;
    logic [LW-1:0] line;
    set = (addr >> 4) % SETS;
    tag = addr >> 6;
    off = addr % LINE_BYTES;
    line_addr = addr - off;
    hit = 1'b0; ev = 1'b0; ev_addr = 0; ev_data = '0; w = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[set][i] && m_tag[set][i] == tag) begin hit = 1'b1; w = i; end
    if (!hit) begin
      w = -1;
      for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[set][i]) w = i;
      if (w < 0) begin
`ifdef DC_PLRU_EN
        w = (WAYS - 1) - m_mru[set];
`else
        w = m_rr;
        m_rr = (m_rr + 1) % WAYS;
`endif
        if (m_dirty[set][w]) begin
          ev = 1'b1;
          ev_addr = m_tag[set][w] * 64 + set * 16;
          ev_data = m_data[set][w];
          mem[ev_addr] = ev_data;
        end
      end
      if (!mem.exists(line_addr)) mem[line_addr] = {$urandom, $urandom, $urandom, $urandom};
      m_valid[set][w] = 1'b1;
      m_dirty[set][w] = 1'b0;
      m_tag[set][w] = tag;
      m_data[set][w] = mem[line_addr];
    end
    m_mru[set] = w;
    line = m_data[set][w];
    rdata = '0;
    if (we) begin
      case (op)
        2'd0: line[off*8 +: 8] = wd[7:0];
        2'd1: line[(off/4)*32 +: 32] = wd[31:0];
        default: line = wd;
      endcase
      m_data[set][w] = line;
      m_dirty[set][w] = 1'b1;
    end else begin
      case (op)
        2'd0: rdata = LW'(line[off*8 +: 8]);
        2'd1: rdata = LW'(line[(off/4)*32 +: 32]);
        default: rdata = line;
      endcase
    end
  endtask

  // driver: one full request including evict/fill service and response checks
  task automatic do_req(input string name, input int addr, input logic we, input logic [1:0] op,
                        input logic [LW-1:0] wd, input int stall, input bit hold,
                        output logic got_hit, output logic [LW-1:0] got_data);
    logic e_hit, e_ev;
    logic [LW-1:0] e_rd, e_evd, ev_d0;
    int e_eva, e_line, ev_a0, cyc, lat;
    bit done, saw_ev, ev_done, saw_fill, stable_ok, order_ok, busy_ok;
    model_access(addr, we, op, wd, e_hit, e_rd, e_ev, e_eva, e_evd, e_line);
    got_hit = 1'bx; got_data = 'x;
    done = 0; saw_ev = 0; ev_done = 0; saw_fill = 0; stable_ok = 1; order_ok = 1; busy_ok = 1;
    ev_a0 = 0; ev_d0 = '0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = ADDR_W'(addr); req_we = we; req_op = op; req_wdata = wd;
    check({name, ":ready_idle"}, req_ready, 1'b1);
    n_req++;
    @(posedge clk);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold) req_valid = 1'b0;
      if (req_ready) busy_ok = 0;
      if (fill_req && e_ev && !ev_done) order_ok = 0;
      evict_ready = 1'b0;
      fill_valid = 1'b0;
      if (evict_valid) begin
        if (!saw_ev) begin saw_ev = 1; ev_a0 = int'(evict_addr); ev_d0 = evict_data; end
        else if (evict_addr !== ADDR_W'(ev_a0) || evict_data !== ev_d0) stable_ok = 0;
        if (stall > 0) stall--;
        else begin evict_ready = 1'b1; ev_done = 1; end
      end
      if (fill_req) begin
        if (!saw_fill) begin
          saw_fill = 1;
          check({name, ":fill_addr"}, fill_addr, e_line);
        end
        if ($urandom_range(0, 2) != 0) begin
          fill_valid = 1'b1;
          fill_data = mem.exists(e_line) ? mem[e_line] : '0;
        end
      end
      if (resp_valid) begin
        done = 1; lat = cyc; got_hit = resp_hit; got_data = resp_data;
      end
    end
    evict_ready = 1'b0;
    fill_valid = 1'b0;
    check({name, ":resp_seen"}, done, 1'b1);
    check({name, ":resp_hit"}, got_hit, e_hit);
    check({name, ":resp_data"}, got_data, e_rd);
    if (e_hit) check({name, ":hit_latency"}, lat, 2);
    check({name, ":evict_seen"}, saw_ev, e_ev);
    if (e_ev) begin
      check({name, ":evict_addr"}, ev_a0, e_eva);
      check({name, ":evict_data"}, ev_d0, e_evd);
      check({name, ":evict_stable"}, stable_ok, 1'b1);
      check({name, ":fill_after_evict"}, order_ok, 1'b1);
    end
    check({name, ":fill_seen"}, saw_fill, !e_hit);
    check({name, ":ready_low_busy"}, busy_ok, 1'b1);
    if (hold) begin
      @(negedge clk);
      check({name, ":ready_after_resp"}, req_ready, 1'b1);
      req_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; evict_ready = 1'b0; fill_valid = 1'b0;
    @(negedge clk);
    check({name, ":rst_req_ready"}, req_ready, 1'b0);
    check({name, ":rst_outputs"}, {resp_valid, resp_hit, evict_valid, fill_req}, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check({name, ":ready_after_rst"}, req_ready, 1'b1);
  endtask

  initial begin
    logic h;
    logic [LW-1:0] d;
    int a, cyc;
    bit saw;
    model_reset();
    mem[32'h40] = 128'h33333333_22222222_11111111_00000000;
    do_reset("init");

    // cold miss, then hit
    do_req("cold_miss", 32'h00040, 1'b0, 2'd1, '0, 0, 0, h, d);
    check("cold_miss_data", d, 128'h0);
    check("cold_miss_hit", h, 1'b0);
    do_req("rehit", 32'h00040, 1'b0, 2'd1, '0, 0, 0, h, d);
    check("rehit_flag", h, 1'b1);
    // byte store then word load
    do_req("byte_store", 32'h00045, 1'b1, 2'd0, 128'hAB, 0, 0, h, d);
    check("byte_store_hit", h, 1'b1);
    do_req("word_load", 32'h00044, 1'b0, 2'd1, '0, 0, 0, h, d);
    check("word_after_byte", d, 128'h1111AB11);
    // second way in set 0, then dirty eviction with backpressure
    do_req("fill_way1", 32'h00000, 1'b0, 2'd2, '0, 0, 0, h, d);
    do_req("dirty_evict", 32'h00080, 1'b0, 2'd2, '0, 3, 0, h, d);

    // replacement policy
    do_reset("repl");
    do_req("repl_a", 32'h00000, 1'b0, 2'd1, '0, 0, 0, h, d);
    do_req("repl_b", 32'h00040, 1'b0, 2'd1, '0, 0, 0, h, d);
    do_req("repl_hit_a", 32'h00000, 1'b0, 2'd1, '0, 0, 0, h, d);
    do_req("repl_miss", 32'h00080, 1'b0, 2'd1, '0, 0, 0, h, d);
    do_req("repl_probe", 32'h00000, 1'b0, 2'd1, '0, 0, 0, h, d);
`ifdef DC_PLRU_EN
    check("repl_plru_kept_a", h, 1'b1);
`else
    check("repl_rr_evicted_a", h, 1'b0);
`endif

    // reset during fill
    do_reset("pre_abort");
    @(negedge clk);
    req_valid = 1'b1; req_addr = 20'h00040; req_we = 1'b0; req_op = 2'd1;
    n_req++;
    @(negedge clk);
    req_valid = 1'b0;
    saw = 0;
    cyc = 0;
    while (!saw && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (fill_req) saw = 1;
    end
    check("abort_fill_req_seen", saw, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_fill_req_drop", fill_req, 1'b0);
    check("abort_ready_low", req_ready, 1'b0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_ready_after", req_ready, 1'b1);
    do_req("abort_reload", 32'h00040, 1'b0, 2'd1, '0, 0, 0, h, d);
    check("abort_reload_miss", h, 1'b0);

    // request held while busy
    do_req("held_miss", 32'h000C4, 1'b1, 2'd1, 128'hDEADBEEF, 0, 1, h, d);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      a = $urandom_range(0, 3) * 64 + $urandom_range(0, SETS - 1) * 16 + $urandom_range(0, LINE_BYTES - 1);
      do_req($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2),
             ($urandom_range(0, 3) == 0), h, d);
    end

    @(negedge clk);
    check("accept_count", acc_count, n_req);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
